// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, requester IDs and default widths for mem_arb.
//   No ports; imported by mem_arb and rr_pick2.
package mem_arb_pkg;
   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 32;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;
   localparam logic ID_IF = 1'b0;
   localparam logic ID_DM = 1'b1;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin pick between fetch (req0) and data (req1).
//   req0_i/req1_i : requests; last_i : ID of the previous winner
//   any_o         : at least one request; win_o : winning ID (ID_IF/ID_DM)
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic req0_i,
   input  logic req1_i,
   input  logic last_i,
   output logic any_o,
   output logic win_o
);
   assign any_o = req0_i | req1_i;
   // DM wins when alone, or on a tie when IF won last time.
   assign win_o = req1_i & (~req0_i | (last_i == ID_IF));
endmodule

// File: rtl/mem_arb.sv
// mem_arb: arbitrates instruction fetch and data requests onto one single-port memory.
//   CLK/RST                          : clock, async active-high reset
//   IF_REQ/IF_ADDR -> IF_GNT/IF_VALID/IF_RDATA          : fetch port
//   DM_REQ/DM_WE/DM_ADDR/DM_WDATA -> DM_GNT/DM_VALID/DM_RDATA : data port
//   MEM_EN/MEM_WE/MEM_ADDR/MEM_WDATA, MEM_RDATA (1-cycle latency) : memory port
//   BUSY                             : state is not IDLE
module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IF_REQ,
   input  logic [ADDR_W-1:0] IF_ADDR,
   output logic              IF_GNT,
   output logic              IF_VALID,
   output logic [DATA_W-1:0] IF_RDATA,
   input  logic              DM_REQ,
   input  logic              DM_WE,
   input  logic [ADDR_W-1:0] DM_ADDR,
   input  logic [DATA_W-1:0] DM_WDATA,
   output logic              DM_GNT,
   output logic              DM_VALID,
   output logic [DATA_W-1:0] DM_RDATA,
   output logic              MEM_EN,
   output logic              MEM_WE,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_WDATA,
   input  logic [DATA_W-1:0] MEM_RDATA,
   output logic              BUSY
);
   state_t            state_q, state_d;
   logic              last_q, last_d, we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, rdata;
   logic              any, pick, take, acc, rsp;

   rr_pick2 u_pick (
      .req0_i (IF_REQ),
      .req1_i (DM_REQ),
      .last_i (last_q),
      .any_o  (any),
      .win_o  (pick)
   );

   // last_q doubles as the in-flight winner: it is rewritten on every grant.
   always_comb begin
      take    = (state_q == IDLE) && any;
      state_d = (state_q == IDLE) ? (any ? ACCESS : IDLE) : (state_q == ACCESS) ? RESP : IDLE;
      last_d  = take ? pick : last_q;
      we_d    = take ? ((pick == ID_DM) && DM_WE) : we_q;
      addr_d  = take ? ((pick == ID_DM) ? DM_ADDR : IF_ADDR) : addr_q;
      wdata_d = take ? ((pick == ID_DM) ? DM_WDATA : '0) : wdata_q;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         last_q  <= ID_DM;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      acc       = (state_q == ACCESS);
      rsp       = (state_q == RESP);
      rdata     = (rsp && !we_q) ? MEM_RDATA : '0;
      IF_GNT    = acc && (last_q == ID_IF);
      DM_GNT    = acc && (last_q == ID_DM);
      IF_VALID  = rsp && (last_q == ID_IF);
      DM_VALID  = rsp && (last_q == ID_DM);
      IF_RDATA  = IF_VALID ? rdata : '0;
      DM_RDATA  = DM_VALID ? rdata : '0;
      MEM_EN    = acc;
      MEM_WE    = acc && we_q;
      MEM_ADDR  = acc ? addr_q : '0;
      MEM_WDATA = acc ? wdata_q : '0;
      BUSY      = (state_q != IDLE);
   end
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: scoreboard bench for mem_arb with a cycle-timeline reference model.
module tb_mem_arb;
   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [31:0] wdata;
   } txn_t;

   logic        CLK = 1'b0, RST = 1'b1;
   logic        IF_REQ = 1'b0, DM_REQ = 1'b0, DM_WE = 1'b0;
   logic [15:0] IF_ADDR = '0, DM_ADDR = '0;
   logic [31:0] DM_WDATA = '0, MEM_RDATA = '0;
   logic        IF_GNT, IF_VALID, DM_GNT, DM_VALID, MEM_EN, MEM_WE, BUSY;
   logic [31:0] IF_RDATA, DM_RDATA, MEM_WDATA;
   logic [15:0] MEM_ADDR;
   logic [10:0] outs;

   txn_t if_q[$], dm_q[$];
   int   glog[$];
   int   n_chk = 0, n_pass = 0;
   int   last_id = 1, cur_g = -1, cur_v = -1;

   mem_arb dut (
      .CLK(CLK), .RST(RST),
      .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(IF_GNT), .IF_VALID(IF_VALID), .IF_RDATA(IF_RDATA),
      .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA),
      .DM_GNT(DM_GNT), .DM_VALID(DM_VALID), .DM_RDATA(DM_RDATA),
      .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
      .MEM_RDATA(MEM_RDATA), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   assign outs = {IF_GNT, IF_VALID, |IF_RDATA, DM_GNT, DM_VALID, |DM_RDATA,
                  MEM_EN, MEM_WE, |MEM_ADDR, |MEM_WDATA, BUSY};

   function automatic logic [31:0] mem_f(logic [15:0] a);
      return (a == 16'h0010) ? 32'h8123_0000 : ({~a, a} ^ 32'h5A5A_0000);
   endfunction

   // Test memory: read data is a fixed function of the address, one cycle after MEM_EN.
   always @(posedge CLK) MEM_RDATA <= MEM_EN ? mem_f(MEM_ADDR) : 32'($urandom);

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Monitor: expected GNT one cycle after an idle sampling cycle, VALID the cycle after.
   always @(negedge CLK) begin : mon
      txn_t        t;
      int          ng;
      logic [31:0] er;
      if (RST) begin
         chk("rst_outputs", outs, 0);
         cur_g = -1;
         cur_v = -1;
         last_id = 1;
         if_q.delete();
         dm_q.delete();
      end else begin
         chk("if_gnt", IF_GNT, cur_g == 0);
         chk("dm_gnt", DM_GNT, cur_g == 1);
         chk("if_valid", IF_VALID, cur_v == 0);
         chk("dm_valid", DM_VALID, cur_v == 1);
         chk("busy", BUSY, cur_g >= 0 || cur_v >= 0);
         chk("mem_en", MEM_EN, cur_g >= 0);
         if (cur_g >= 0) begin
            chk("grant_queue", (cur_g == 0 ? if_q.size() : dm_q.size()) > 0, 1);
            if ((cur_g == 0 ? if_q.size() : dm_q.size()) > 0) begin
               t = (cur_g == 0) ? if_q[0] : dm_q[0];
               chk("mem_addr", MEM_ADDR, t.addr);
               chk("mem_we", MEM_WE, t.we);
               if (t.we) chk("mem_wdata", MEM_WDATA, t.wdata);
            end
            glog.push_back(cur_g);
         end else chk("mem_idle", {MEM_WE, |MEM_ADDR, |MEM_WDATA}, 0);
         if (cur_v >= 0) begin
            chk("valid_queue", (cur_v == 0 ? if_q.size() : dm_q.size()) > 0, 1);
            if ((cur_v == 0 ? if_q.size() : dm_q.size()) > 0) begin
               t  = (cur_v == 0) ? if_q.pop_front() : dm_q.pop_front();
               er = t.we ? 32'h0 : mem_f(t.addr);
               if (cur_v == 0) begin
                  chk("if_rdata", IF_RDATA, er);
                  chk("dm_rdata_quiet", DM_RDATA, 0);
               end else begin
                  chk("dm_rdata", DM_RDATA, er);
                  chk("if_rdata_quiet", IF_RDATA, 0);
               end
            end
         end else chk("rdata_idle", {IF_RDATA, DM_RDATA}, 0);
         ng = -1;
         if (cur_g < 0 && cur_v < 0) begin
            ng = (IF_REQ && DM_REQ) ? 1 - last_id : IF_REQ ? 0 : DM_REQ ? 1 : -1;
            if (ng >= 0) last_id = ng;
         end
         cur_v = cur_g;
         cur_g = ng;
      end
   end

   task automatic do_if(logic [15:0] a);
      txn_t t;
      bit   got = 0;
      t.we = 0; t.addr = a; t.wdata = 0;
      if_q.push_back(t);
      IF_REQ = 1; IF_ADDR = a;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge CLK);
         got = IF_GNT;
      end
      chk("if_gnt_wait", got, 1);
      @(posedge CLK); #2;
      IF_REQ = 0; IF_ADDR = 16'($urandom);
   endtask

   task automatic do_dm(logic we, logic [15:0] a, logic [31:0] d);
      txn_t t;
      bit   got = 0;
      t.we = we; t.addr = a; t.wdata = d;
      dm_q.push_back(t);
      DM_REQ = 1; DM_WE = we; DM_ADDR = a; DM_WDATA = d;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge CLK);
         got = DM_GNT;
      end
      chk("dm_gnt_wait", got, 1);
      @(posedge CLK); #2;
      DM_REQ = 0; DM_WE = 1'($urandom); DM_ADDR = 16'($urandom); DM_WDATA = $urandom;
   endtask

   initial begin
      txn_t t;
      repeat (3) @(posedge CLK);
      #2 RST = 0;
      do_if(16'h0010);
      do_dm(1'b1, 16'h0040, 32'hDEAD_BEEF);
      do_dm(1'b0, 16'h0040, 32'h0);
      @(posedge CLK); #2 RST = 1;
      glog.delete();
      @(posedge CLK); #2 RST = 0;
      fork
         repeat (3) do_if(16'($urandom));
         repeat (3) do_dm(1'($urandom), 16'($urandom), $urandom);
      join
      chk("tie_order_len", glog.size(), 6);
      for (int i = 0; i < 6 && i < glog.size(); i++) chk("tie_order", glog[i], i % 2);
      fork
         do_if(16'h0100);
         begin
            @(posedge CLK); #2;
            do_dm(1'b0, 16'h0200, 32'h0);
         end
      join
      @(posedge CLK); #2;
      t.we = 0; t.addr = 16'h0300; t.wdata = 0;
      if_q.push_back(t);
      IF_REQ = 1; IF_ADDR = 16'h0300;
      @(posedge CLK); #2;
      chk("pre_rst_gnt", IF_GNT, 1);
      RST = 1; IF_REQ = 0;
      #1 chk("rst_async", outs, 0);
      @(posedge CLK); #2 RST = 0;
      do_if(16'h0010);
      fork
         repeat (20) begin
            repeat ($urandom_range(0, 3)) begin @(posedge CLK); #2; end
            do_if(16'($urandom));
         end
         repeat (20) begin
            repeat ($urandom_range(0, 3)) begin @(posedge CLK); #2; end
            do_dm(1'($urandom), 16'($urandom), $urandom);
         end
      join
      repeat (5) @(posedge CLK);
      chk("if_q_drained", if_q.size(), 0);
      chk("dm_q_drained", dm_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
